// File: rtl/uart_tx_queue.sv
// Buffered UART transmit path: switch and keyboard byte strobes feed a FIFO that a
// framed serial transmitter (optional parity, one or two stop bits) drains back-to-back.
module uart_tx_queue #(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 9600,
    parameter int DEPTH     = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sw_valid,
    input  logic [7:0]             sw_data,
    input  logic                   kb_valid,
    input  logic [7:0]             kb_data,
    input  logic                   clr_ovf,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             last_sent,
    output logic                   overflow
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int BW  = $clog2(STOP_BITS * DIV + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DIV - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [7:0] data);
        return (PARITY == 2) ? ~(^data) : (^data);
    endfunction

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      last_q, last_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [DEPTH];
    logic [CW-1:0]   free_s;
    logic [PW-1:0]   kb_addr_s;
    logic            wr_sw_s, wr_kb_s, drop_s, pop_s;

    // Write admission: free space is judged before any pop in the same cycle
    always_comb begin
        free_s    = DEPTH_C - cnt_q;
        wr_sw_s   = sw_valid && (free_s != {CW{1'b0}});
        wr_kb_s   = kb_valid && (sw_valid ? (free_s > CW'(1)) : (free_s != {CW{1'b0}}));
        drop_s    = (sw_valid && !wr_sw_s) || (kb_valid && !wr_kb_s);
        kb_addr_s = wr_ptr_q + PW'(wr_sw_s);
        cnt_d     = cnt_q + CW'(wr_sw_s) + CW'(wr_kb_s) - CW'(pop_s);
        wr_ptr_d  = wr_ptr_q + PW'(wr_sw_s) + PW'(wr_kb_s);
        rd_ptr_d  = rd_ptr_q + PW'(pop_s);
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Transmit FSM next state and registered line outputs
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cnt_q != {CW{1'b0}}) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    last_d  = mem_q[rd_ptr_q];
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START, S_PAR: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = {BW{1'b0}};
                    state_d = (state_q == S_START) ? S_DATA : S_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = {BW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == STOP_LAST) begin
                    baud_d  = {BW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                baud_d  = {BW{1'b0}};
                state_d = S_IDLE;
            end
        endcase

        case (state_q)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            S_PAR:   tx_d = parity_bit(last_q);
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE);
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            if (wr_sw_s) begin
                mem_q[wr_ptr_q] <= sw_data;
            end
            if (wr_kb_s) begin
                mem_q[kb_addr_s] <= kb_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Transmitter state and line registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            last_q  <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign count     = cnt_q;
    assign last_sent = last_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: three configurations share stimulus; a frame-level queue
// model predicts every output each cycle, and literal expectations pin the model.
module tb_uart_tx_queue;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;
    localparam int NI    = 3;
    localparam int HLEN  = 240;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sw_valid = 1'b0, kb_valid = 1'b0, clr_ovf = 1'b0;
    logic [7:0] sw_data = 8'h00, kb_data = 8'h00;
    logic       tx_s [NI];
    logic       busy_s [NI];
    logic [2:0] cnt_s [NI];
    logic [7:0] last_s [NI];
    logic       ovf_s [NI];

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_queue #(.CLK_HZ(1000), .BAUD(100), .DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .sw_valid(sw_valid), .sw_data(sw_data),
        .kb_valid(kb_valid), .kb_data(kb_data), .clr_ovf(clr_ovf),
        .tx(tx_s[0]), .busy(busy_s[0]), .count(cnt_s[0]), .last_sent(last_s[0]), .overflow(ovf_s[0]));
    uart_tx_queue #(.CLK_HZ(1000), .BAUD(100), .DEPTH(DEPTH), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sw_valid(sw_valid), .sw_data(sw_data),
        .kb_valid(kb_valid), .kb_data(kb_data), .clr_ovf(clr_ovf),
        .tx(tx_s[1]), .busy(busy_s[1]), .count(cnt_s[1]), .last_sent(last_s[1]), .overflow(ovf_s[1]));
    uart_tx_queue #(.CLK_HZ(1000), .BAUD(100), .DEPTH(DEPTH), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .sw_valid(sw_valid), .sw_data(sw_data),
        .kb_valid(kb_valid), .kb_data(kb_data), .clr_ovf(clr_ovf),
        .tx(tx_s[2]), .busy(busy_s[2]), .count(cnt_s[2]), .last_sent(last_s[2]), .overflow(ovf_s[2]));

    always #5 clk = ~clk;

    // Inputs as seen by the DUT at each rising edge
    logic       c_rst = 1'b0, c_sw = 1'b0, c_kb = 1'b0, c_clr = 1'b0;
    logic [7:0] c_sd = 8'h00, c_kd = 8'h00;
    always @(posedge clk) begin
        c_rst <= reset_n;
        c_sw  <= sw_valid;
        c_sd  <= sw_data;
        c_kb  <= kb_valid;
        c_kd  <= kb_data;
        c_clr <= clr_ovf;
    end

    // Behavioural model: byte queue plus a per-cycle line waveform for the frame in flight
    logic [7:0] mq [NI][$];
    bit         wave [NI][$];
    bit         m_tx [NI];
    bit         m_busy [NI];
    logic [7:0] m_last [NI];
    bit         m_ovf [NI];

    function automatic int par_of(input int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    function automatic int stop_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    task automatic build_frame(input int i, input logic [7:0] b);
        bit pb;
        for (int k = 0; k < DIV; k++) wave[i].push_back(1'b0);
        for (int d = 0; d < 8; d++)
            for (int k = 0; k < DIV; k++) wave[i].push_back(b[d]);
        if (par_of(i) != 0) begin
            pb = (^b) ^ (par_of(i) == 2);
            for (int k = 0; k < DIV; k++) wave[i].push_back(pb);
        end
        for (int k = 0; k < stop_of(i) * DIV; k++) wave[i].push_back(1'b1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            wave[i].delete();
            m_tx[i] = 1'b1;
            m_busy[i] = 1'b0;
            m_last[i] = 8'h00;
            m_ovf[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int free_n;
        bit idle_now, drop;
        logic [7:0] b;
        idle_now = (wave[i].size() == 0);
        free_n = DEPTH - mq[i].size();
        if (!idle_now) begin
            m_tx[i] = wave[i].pop_front();
            m_busy[i] = 1'b1;
        end else begin
            m_tx[i] = 1'b1;
            m_busy[i] = 1'b0;
        end
        if (idle_now && mq[i].size() != 0) begin
            b = mq[i].pop_front();
            m_last[i] = b;
            build_frame(i, b);
        end
        drop = 1'b0;
        if (c_sw) begin
            if (free_n >= 1) begin mq[i].push_back(c_sd); free_n--; end
            else drop = 1'b1;
        end
        if (c_kb) begin
            if (free_n >= 1) begin mq[i].push_back(c_kd); free_n--; end
            else drop = 1'b1;
        end
        if (drop) m_ovf[i] = 1'b1;
        else if (c_clr) m_ovf[i] = 1'b0;
    endtask

    // Advance the model for the edge just passed and compare every output
    always @(negedge clk) begin
        if (!reset_n || !c_rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                model_step(i);
                n_cmp++;
                if (tx_s[i] !== m_tx[i] || busy_s[i] !== m_busy[i] || int'(cnt_s[i]) != mq[i].size()
                    || last_s[i] !== m_last[i] || ovf_s[i] !== m_ovf[i]) begin
                    n_bad++;
                    $display("FAIL model_dut%0d t=%0t: actual tx=%0b busy=%0b count=%0d last=%02h ovf=%0b required tx=%0b busy=%0b count=%0d last=%02h ovf=%0b",
                             i, $time, tx_s[i], busy_s[i], cnt_s[i], last_s[i], ovf_s[i],
                             m_tx[i], m_busy[i], mq[i].size(), m_last[i], m_ovf[i]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input bit sv, input logic [7:0] sd, input bit kv, input logic [7:0] kd, input bit clr);
        sw_valid = sv; sw_data = sd; kb_valid = kv; kb_data = kd; clr_ovf = clr;
        @(negedge clk);
        sw_valid = 1'b0; kb_valid = 1'b0; clr_ovf = 1'b0;
    endtask

    logic hx [NI][HLEN];
    logic hb [NI][HLEN];
    logic [2:0] hc0 [HLEN];
    logic [7:0] hl0 [HLEN];

    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                hx[i][c] = tx_s[i];
                hb[i][c] = busy_s[i];
            end
            hc0[c] = cnt_s[0];
            hl0[c] = last_s[0];
        end
    endtask

    function automatic int busy_sum(input int i, input int n);
        int s = 0;
        for (int c = 0; c < n; c++) s += int'(hb[i][c]);
        return s;
    endfunction

    function automatic bit all_idle();
        bit r = 1'b1;
        for (int i = 0; i < NI; i++)
            if (busy_s[i] !== 1'b0 || cnt_s[i] !== 3'd0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle();
        int k = 0;
        int quiet = 0;
        while (quiet < 3 && k < 3000) begin
            @(negedge clk);
            k++;
            if (all_idle()) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait: actual busy after %0d cycles, required idle", k);
        end
    endtask

    logic [9:0] pat_a5;

    initial begin
        pat_a5 = 10'b1101001010;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_tx", 32'(tx_s[i]), 32'd1);
            check("rst_busy", 32'(busy_s[i]), 32'd0);
            check("rst_count", 32'(cnt_s[i]), 32'd0);
            check("rst_last", 32'(last_s[i]), 32'h00);
            check("rst_ovf", 32'(ovf_s[i]), 32'd0);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5: waveform, latency, busy length
        send(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        check("a5_count_after_strobe", 32'(cnt_s[0]), 32'd1);
        check("a5_tx_idle_after_strobe", 32'(tx_s[0]), 32'd1);
        capture(130);
        check("a5_tx_still_high", 32'(hx[0][0]), 32'd1);
        check("a5_count_after_pop", 32'(hc0[0]), 32'd0);
        check("a5_last_sent", 32'(hl0[0]), 32'hA5);
        check("a5_tx_falls", 32'(hx[0][1]), 32'd0);
        for (int b = 0; b < 10; b++) check("a5_line_bit", 32'(hx[0][5 + 10 * b]), 32'(pat_a5[b]));
        check("a5_busy_len0", 32'(busy_sum(0, 130)), 32'd100);
        check("a5_busy_len1", 32'(busy_sum(1, 130)), 32'd120);
        check("a5_busy_len2", 32'(busy_sum(2, 130)), 32'd110);
        wait_idle();

        // Both sources in one cycle, then back-to-back frames
        send(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        check("dual_count", 32'(cnt_s[0]), 32'd2);
        capture(140);
        check("b2b_frame1_bit0", 32'(hx[0][15]), 32'd1);
        check("b2b_stop", 32'(hx[0][100]), 32'd1);
        check("b2b_gap_tx", 32'(hx[0][101]), 32'd1);
        check("b2b_gap_busy", 32'(hb[0][101]), 32'd0);
        check("b2b_start2", 32'(hx[0][102]), 32'd0);
        check("b2b_frame2_bit0", 32'(hx[0][117]), 32'd0);
        check("b2b_frame2_bit1", 32'(hx[0][127]), 32'd1);
        wait_idle();

        // Five single writes behind an active frame; fifth is dropped
        send(1'b1, 8'h31, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) send(1'b1, 8'(8'h32 + k), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check("fill_count", 32'(cnt_s[i]), 32'd4);
            check("fill_ovf", 32'(ovf_s[i]), 32'd1);
        end
        send(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("clr_ovf", 32'(ovf_s[0]), 32'd0);
        wait_idle();

        // count=3 then both strobes: sw kept, kb dropped
        send(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) send(1'b1, 8'(8'h42 + k), 1'b0, 8'h00, 1'b0);
        check("three_count", 32'(cnt_s[0]), 32'd3);
        send(1'b1, 8'h45, 1'b1, 8'h46, 1'b0);
        check("one_free_count", 32'(cnt_s[0]), 32'd4);
        check("one_free_ovf", 32'(ovf_s[0]), 32'd1);
        send(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        wait_idle();
        check("order_last_sent", 32'(last_s[0]), 32'h45);

        // Parity and two stop bits with 0x07
        send(1'b1, 8'h07, 1'b0, 8'h00, 1'b0);
        capture(130);
        check("even_parity_bit", 32'(hx[1][96]), 32'd1);
        check("odd_parity_bit", 32'(hx[2][96]), 32'd0);
        check("stop2_second_half", 32'(hx[1][115]), 32'd1);
        check("stop2_frame_len", 32'(busy_sum(1, 130)), 32'd120);
        wait_idle();

        // Reset in the middle of DATA with two bytes queued
        send(1'b1, 8'h51, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        send(1'b1, 8'h52, 1'b0, 8'h00, 1'b0);
        send(1'b1, 8'h53, 1'b0, 8'h00, 1'b0);
        check("prereset_count", 32'(cnt_s[0]), 32'd2);
        repeat (25) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("midrst_tx", 32'(tx_s[i]), 32'd1);
            check("midrst_busy", 32'(busy_s[i]), 32'd0);
            check("midrst_count", 32'(cnt_s[i]), 32'd0);
            check("midrst_last", 32'(last_s[i]), 32'h00);
        end
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("postrst_busy", 32'(busy_s[0]), 32'd0);
        check("postrst_tx", 32'(tx_s[0]), 32'd1);
        check("postrst_count", 32'(cnt_s[0]), 32'd0);

        // Random traffic against the model
        for (int t = 0; t < 3000; t++) begin
            sw_valid = ($urandom_range(99) < 3);
            kb_valid = ($urandom_range(99) < 3);
            sw_data  = 8'($urandom);
            kb_data  = 8'($urandom);
            clr_ovf  = ($urandom_range(49) == 0);
            @(negedge clk);
        end
        sw_valid = 1'b0; kb_valid = 1'b0; clr_ovf = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Buffered, parametrised UART transmit path replacing the single-shot send-on-button scheme. Two byte sources feed a FIFO of configurable depth:
- switch/button path
- PS/2 keyboard new-code path

A framed UART transmitter drains the FIFO back-to-back at a configurable baud rate, with optional parity and stop-bit count. Status outputs (fill count, busy, last byte sent, sticky overflow) drive the seven-segment display and LEDs in the top level.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = CLK_HZ/BAUD (integer division), DIV >= 2
DEPTH, 16, FIFO entries; power of two, >= 2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sw_valid  in  1  single-cycle strobe: enqueue sw_data
sw_data  in  8  byte from switches
kb_valid  in  1  single-cycle strobe: enqueue kb_data (keyboard new_code)
kb_data  in  8  keyboard scancode
clr_ovf  in  1  clears overflow flag
tx  out  1  UART serial output, idle high
busy  out  1  high while a frame is on the line
count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
last_sent  out  8  byte of the most recently started frame
overflow  out  1  sticky: a write was dropped

Behaviour:
Reset (asynchronous, reset_n=0), including mid-frame:
- tx=1, busy=0, count=0, last_sent=0x00, overflow=0
- FIFO pointers and baud counter zeroed; FSM to IDLE
- No partial frame resumes after release

Write side (registered, evaluated at each edge):
- free = DEPTH - count, taken before any same-cycle pop.
- sw_valid only: written if free >= 1.
- kb_valid only: written if free >= 1.
- Both valid in the same cycle, free >= 2: both written, sw_data first (older), then kb_data.
- Both valid in the same cycle, free == 1: sw_data written, kb_data dropped.
- Any dropped byte sets overflow=1.
- overflow clears only on clr_ovf, or on a cycle with clr_ovf=1 and no drop. A drop in the same cycle as clr_ovf wins: overflow stays 1.

Read side:
- Occupancy update: count_next = count + writes - pop; pop is 0 or 1.
- A pop at full frees space only for the following cycle.

Transmit FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: tx=1, busy=0. If count != 0, pop head into shift register, last_sent <= head, baud counter <= 0, go to START.
- START: tx=0 for DIV cycles.
- DATA: 8 bits, LSB first, each DIV cycles.
- PAR: present only if PARITY != 0. Bit value is XOR of the data bits (even) or its inverse (odd). Lasts DIV cycles.
- STOP: tx=1 for STOP_BITS*DIV cycles, then back to IDLE.

Frame timing and output behaviour:
- busy=1 in every state except IDLE.
- tx is a registered output.
- Frame length = DIV*(10 + (PARITY!=0) + (STOP_BITS-1)) cycles.
- Back-to-back frames: STOP→IDLE→START, so one idle-high cycle separates frames.

Latency:
- Enqueue into an empty FIFO with the FSM in IDLE: the strobe is sampled at edge N, count=1 after edge N, and tx falls at edge N+2.

Width rules:
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
- count is one bit wider so it can represent full.

Test Plan:
(Bench parameters: CLK_HZ=1000, BAUD=100 → DIV=10, DEPTH=4, PARITY=0, STOP_BITS=1 unless noted.)
- Single sw_valid with sw_data=0xA5 → tx low at 2nd edge after strobe. Line 0,1,0,1,0,0,1,0,1,1, each 10 cycles. busy high for 100 cycles. last_sent=0xA5. count 1→0.
- sw_valid and kb_valid in the same cycle, 0x11 and 0x22, FIFO empty → count=2. Frames 0x11 then 0x22, separated by exactly one idle cycle.
- Fill with 5 single writes while a frame is active, DEPTH=4 → count saturates at 4, fifth byte dropped, overflow=1. Pulse clr_ovf → overflow=0.
- count=3, both strobes in the same cycle → sw byte accepted, kb byte dropped, count=4, overflow=1. Transmit order preserved.
- PARITY=1 sending 0x07 → parity bit 1. PARITY=2 sending 0x07 → parity bit 0. STOP_BITS=2 → stop high for 20 cycles, frame 120 cycles.
- Assert reset_n=0 mid-DATA with 2 bytes queued → tx=1, busy=0, count=0 immediately. No transmission after release until a new strobe.
